// File: rtl/aes_blk_ctrl.sv
// aes_blk_ctrl: block-sequencing controller for the AES datapath with key phase, chaining and abort
module aes_blk_ctrl #(
  parameter int NR      = 10,
  parameter int KEY_CYC = 10,
  parameter int CNT_W   = 16,
  localparam int RW     = $clog2(NR + 1),
  localparam int KW     = (KEY_CYC > 1) ? $clog2(KEY_CYC) : 1
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iStart,
  input  logic             iKeyNew,
  input  logic             iCont,
  input  logic             iAbort,
  input  logic             iOutRdy,
  output logic             oStartKey,
  output logic             oStart,
  output logic [RW-1:0]    oRound,
  output logic             oLast,
  output logic             oValid,
  output logic             oReady,
  output logic             oEnd,
  output logic [CNT_W-1:0] oBlkCnt
);
  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    KEY  = 4'b0010,
    RUN  = 4'b0100,
    HOLD = 4'b1000
  } state_t;
  state_t state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [KW-1:0] kcnt_q, kcnt_d;
  logic [CNT_W-1:0] blk_q, blk_d;
  logic key_ok_q, key_ok_d, valid_q, ready_q;
  logic need_key;
  assign need_key = iKeyNew | ~key_ok_q;
  assign oRound   = round_q;
  assign oValid   = valid_q;
  assign oReady   = ready_q;
  assign oBlkCnt  = blk_q;
  assign oLast    = (state_q == RUN) && (round_q == RW'(NR));
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q  <= IDLE;
      round_q  <= '0;
      kcnt_q   <= '0;
      blk_q    <= '0;
      key_ok_q <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      kcnt_q   <= kcnt_d;
      blk_q    <= blk_d;
      key_ok_q <= key_ok_d;
      valid_q  <= (state_d == HOLD);
      ready_q  <= (state_d == IDLE);
    end
  end
  always_comb begin
    state_d   = state_q;
    round_d   = '0;
    kcnt_d    = kcnt_q;
    blk_d     = blk_q;
    key_ok_d  = key_ok_q;
    oStartKey = 1'b0;
    oStart    = 1'b0;
    oEnd      = 1'b0;
    case (state_q)
      IDLE: if (iStart) begin
        oStartKey = need_key;
        if (need_key && KEY_CYC > 0) begin
          state_d = KEY;
          kcnt_d  = KW'(KEY_CYC > 0 ? KEY_CYC - 1 : 0);
        end else begin
          oStart   = 1'b1;
          key_ok_d = 1'b1;
          state_d  = RUN;
          round_d  = RW'(1);
          blk_d    = '0;
        end
      end
      KEY: begin
        kcnt_d = kcnt_q - KW'(1);
        if (kcnt_q == '0) begin
          oStart   = 1'b1;
          key_ok_d = 1'b1;
          state_d  = RUN;
          round_d  = RW'(1);
          blk_d    = '0;
        end
      end
      RUN: begin
        round_d = round_q + RW'(1);
        if (round_q == RW'(NR)) begin
          state_d = HOLD;
          round_d = '0;
        end
      end
      HOLD: if (iOutRdy) begin
        blk_d = blk_q + CNT_W'(1);
        if (iCont) begin
          oStart  = 1'b1;
          state_d = RUN;
          round_d = RW'(1);
        end else begin
          oEnd    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // abort overrides everything; the key survives unless its expansion was cut short
    if (iAbort) begin
      state_d   = IDLE;
      round_d   = '0;
      kcnt_d    = kcnt_q;
      blk_d     = blk_q;
      key_ok_d  = (state_q == KEY) ? 1'b0 : key_ok_q;
      oStartKey = 1'b0;
      oStart    = 1'b0;
      oEnd      = 1'b0;
    end
  end
endmodule

// File: tb/tb_aes_blk_ctrl.sv
// tb_aes_blk_ctrl: scoreboard bench; valid-rise cycle and block count are queued by stimulus, checked by a monitor
module tb_aes_blk_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, b_start = 1'b0, key_new = 1'b0, cont = 1'b0, abort = 1'b0, out_rdy = 1'b0;
  logic a_sk, a_st, a_last, a_val, a_rdy, a_end;
  logic [3:0] a_rnd;
  logic [15:0] a_cnt;
  logic b_sk, b_st, b_last, b_val, b_rdy, b_end;
  logic [1:0] b_rnd, b_cnt;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct {int cyc; int cnt;} exp_t;
  exp_t q[$];
  exp_t e;
  logic valid_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_blk_ctrl #(.NR(10), .KEY_CYC(10), .CNT_W(16)) dut_a (
    .iClk(clk), .iRstN(rst_n), .iStart(start), .iKeyNew(key_new), .iCont(cont),
    .iAbort(abort), .iOutRdy(out_rdy), .oStartKey(a_sk), .oStart(a_st), .oRound(a_rnd),
    .oLast(a_last), .oValid(a_val), .oReady(a_rdy), .oEnd(a_end), .oBlkCnt(a_cnt));

  aes_blk_ctrl #(.NR(3), .KEY_CYC(0), .CNT_W(2)) dut_b (
    .iClk(clk), .iRstN(rst_n), .iStart(b_start), .iKeyNew(key_new), .iCont(cont),
    .iAbort(abort), .iOutRdy(out_rdy), .oStartKey(b_sk), .oStart(b_st), .oRound(b_rnd),
    .oLast(b_last), .oValid(b_val), .oReady(b_rdy), .oEnd(b_end), .oBlkCnt(b_cnt));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40 && !a_val; i++) step();
    chk("valid_seen", a_val, 1);
  endtask

  always @(negedge clk) begin
    if (a_val && !valid_prev) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("valid_blkcnt", a_cnt, e.cnt);
        chk("valid_round0", a_rnd, 0);
      end
    end
    valid_prev <= a_val;
  end

  initial begin
    step(); step();
    chk("rst_ready", a_rdy, 0);
    chk("rst_valid", a_val, 0);
    chk("rst_round", a_rnd, 0);
    chk("rst_cnt", a_cnt, 0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", a_rdy, 1);
    // T1: new key session
    start = 1; key_new = 1; #1;
    chk("t1_startkey", a_sk, 1);
    chk("t1_nostart", a_st, 0);
    q.push_back('{cyc + 21, 0});
    step(); start = 0; key_new = 0; #1;
    chk("t1_ready_low", a_rdy, 0);
    chk("t1_sk_pulse", a_sk, 0);
    for (int i = 0; i < 9; i++) step();
    chk("t1_key_start", a_st, 1);
    for (int r = 1; r <= 10; r++) begin
      step();
      chk("t1_round", a_rnd, r);
      chk("t1_last", a_last, r == 10);
    end
    step();
    out_rdy = 1; cont = 0; #1;
    chk("t1_end", a_end, 1);
    step(); out_rdy = 0;
    chk("t1_valid_drop", a_val, 0);
    chk("t1_cnt", a_cnt, 1);
    chk("t1_ready", a_rdy, 1);
    // T2: key reuse
    start = 1; key_new = 0; #1;
    chk("t2_no_sk", a_sk, 0);
    chk("t2_start", a_st, 1);
    q.push_back('{cyc + 11, 0});
    step(); start = 0;
    wait_valid();
    out_rdy = 1; #1;
    chk("t2_end", a_end, 1);
    step(); out_rdy = 0;
    chk("t2_cnt", a_cnt, 1);
    // T4: four chained blocks with zero bubble
    start = 1; q.push_back('{cyc + 11, 0});
    step(); start = 0;
    for (int k = 0; k < 4; k++) begin
      wait_valid();
      out_rdy = 1; cont = (k < 3); #1;
      chk("t4_start", a_st, k < 3);
      chk("t4_end", a_end, k == 3);
      if (k < 3) q.push_back('{cyc + 11, k + 1});
      step(); out_rdy = 0; cont = 0;
      if (k < 3) chk("t4_no_bubble", a_rnd, 1);
    end
    chk("t4_cnt", a_cnt, 4);
    chk("t4_ready", a_rdy, 1);
    // T4b: backpressure holds oValid
    start = 1; q.push_back('{cyc + 11, 0});
    step(); start = 0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold", a_val, 1);
    end
    out_rdy = 1; cont = 1; #1;
    chk("t4_hold_start", a_st, 1);
    q.push_back('{cyc + 11, 1});
    step(); out_rdy = 0; cont = 0;
    wait_valid();
    out_rdy = 1; step(); out_rdy = 0;
    chk("t4_hold_cnt", a_cnt, 2);
    // T5: abort in KEY
    start = 1; key_new = 1;
    step(); start = 0; key_new = 0;
    step(); step(); step();
    abort = 1; #1;
    chk("t5_key_abort_nost", a_st, 0);
    step(); abort = 0;
    chk("t5_key_abort_rdy", a_rdy, 1);
    chk("t5_key_abort_cnt", a_cnt, 2);
    chk("t5_key_abort_rnd", a_rnd, 0);
    start = 1; #1;
    chk("t5_key_ok_cleared", a_sk, 1);
    step(); start = 0;
    for (int i = 0; i < 14; i++) step();
    chk("t5_round5", a_rnd, 5);
    abort = 1; #1;
    step(); abort = 0;
    chk("t5_run_abort_rnd", a_rnd, 0);
    chk("t5_run_abort_rdy", a_rdy, 1);
    chk("t5_run_abort_val", a_val, 0);
    chk("t5_run_abort_cnt", a_cnt, 0);
    // abort in HOLD together with iOutRdy
    start = 1; #1;
    chk("t5_key_kept", a_sk, 0);
    q.push_back('{cyc + 11, 0});
    step(); start = 0;
    wait_valid();
    out_rdy = 1; cont = 1; q.push_back('{cyc + 11, 1});
    step(); out_rdy = 0; cont = 0;
    wait_valid();
    abort = 1; out_rdy = 1; #1;
    chk("t5_hold_abort_noend", a_end, 0);
    chk("t5_hold_abort_nost", a_st, 0);
    step(); abort = 0; out_rdy = 0;
    chk("t5_hold_abort_val", a_val, 0);
    chk("t5_hold_abort_cnt", a_cnt, 1);
    chk("t5_hold_abort_rdy", a_rdy, 1);
    // reset mid-RUN
    start = 1; step(); start = 0;
    step(); step(); step();
    chk("t5_round4", a_rnd, 4);
    rst_n = 0; #1;
    chk("t5_rst_rnd", a_rnd, 0);
    chk("t5_rst_rdy", a_rdy, 0);
    chk("t5_rst_cnt", a_cnt, 0);
    step(); rst_n = 1; step();
    // T3: key_ok lost through reset forces key phase
    start = 1; key_new = 0; #1;
    chk("t3_sk", a_sk, 1);
    chk("t3_nost", a_st, 0);
    q.push_back('{cyc + 21, 0});
    step(); start = 0;
    wait_valid();
    out_rdy = 1; step(); out_rdy = 0;
    chk("t3_cnt", a_cnt, 1);
    // T6: counter wrap on the small instance, KEY_CYC=0
    rst_n = 0; step(); rst_n = 1; step();
    b_start = 1; key_new = 1; #1;
    chk("t6_sk", b_sk, 1);
    chk("t6_st", b_st, 1);
    step(); b_start = 0; key_new = 0;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 20 && !b_val; i++) step();
      chk("t6_valid_seen", b_val, 1);
      chk("t6_cnt_before", b_cnt, k % 4);
      out_rdy = 1; cont = (k < 4);
      step(); out_rdy = 0; cont = 0;
      chk("t6_cnt_after", b_cnt, (k + 1) % 4);
    end
    chk("t6_ready", b_rdy, 1);
    step(); step();
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
